draw_text_box: RTL

- Parametrised text-window overlay for the VGA pipeline. Draws a COLS x ROWS grid of 8-pixel-wide, FONT_H-line-tall glyphs at (XPOS, YPOS) over the incoming background.
- Drives a linear character address and glyph line to the external char-RAM/font-ROM chain. Consumes the returned 8-bit glyph row after a parametrised lookup latency.
- Adds over the previous generation:
  - configurable grid geometry;
  - correct MSB-first bit selection;
  - run-time fg/bg colours;
  - transparent-background mode;
  - blinking inverse cursor cell.

---
 rtl/draw_text_box.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/draw_text_box.sv
// draw_text_box: text-window overlay for the VGA pipeline.
// Draws a COLS x ROWS grid of 8-pixel-wide, FONT_H-line glyphs at (XPOS, YPOS).
// It drives a character address and glyph line to an external char-RAM/font-ROM
// chain and composites the returned glyph row ROM_LAT cycles later. A cursor
// cell can be shown inverted and made to blink.
module draw_text_box #(
  parameter int XPOS         = 165,
  parameter int YPOS         = 60,
  parameter int COLS         = 13,
  parameter int ROWS         = 16,
  parameter int FONT_H       = 16,
  parameter int ADDR_W       = 8,
  parameter int ROM_LAT      = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [11:0]       hcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic [11:0]       vcount_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic [11:0]       fg_rgb,
  input  logic [11:0]       bg_rgb,
  input  logic              transparent,
  input  logic              cursor_en,
  input  logic [7:0]        cursor_col,
  input  logic [7:0]        cursor_row,
  input  logic [7:0]        char_pixel,
  output logic [ADDR_W-1:0] char_addr,
  output logic [3:0]        char_line,
  output logic [11:0]       hcount_out,
  output logic [11:0]       vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out
);

  localparam int LOG_H = $clog2(FONT_H);
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Box bounds are kept one bit wider than the counters so a box running past
  // 4095 does not wrap around.
  localparam logic [12:0] X_LO = 13'(XPOS);
  localparam logic [12:0] X_HI = 13'(XPOS + 8 * COLS);
  localparam logic [12:0] Y_LO = 13'(YPOS);
  localparam logic [12:0] Y_HI = 13'(YPOS + FONT_H * ROWS);

  // Everything about a pixel that must wait for the font ROM to answer.
  typedef struct packed {
    logic        in_box;
    logic [2:0]  sub_x;
    logic        cursor_hit;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic [11:0] rgb;
    logic [11:0] fg;
    logic [11:0] bg;
    logic        transparent;
  } pix_t;

  logic [11:0]       rel_x;
  logic [11:0]       rel_y;
  logic [8:0]        col;
  logic [11:0]       row;
  logic              in_box;
  logic [ADDR_W-1:0] cell_addr;
  logic [3:0]        cell_line;
  pix_t              stage0;
  pix_t              pipe [ROM_LAT+1];

  logic              vsync_prev;
  logic [FW-1:0]     frame_cnt;
  logic              blink_phase;

  pix_t              last;
  logic              glyph_bit;
  logic [11:0]       rgb_next;

  // Stage 0: locate the incoming pixel inside the character grid.
  always_comb begin
    rel_x     = hcount_in - 12'(XPOS);
    rel_y     = vcount_in - 12'(YPOS);
    col       = rel_x[11:3];
    row       = rel_y >> LOG_H;
    in_box    = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
    cell_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    cell_line = rel_y[3:0] & 4'(FONT_H - 1);

    stage0             = '0;
    stage0.in_box      = in_box;
    stage0.sub_x       = rel_x[2:0];
    stage0.cursor_hit  = cursor_en && blink_phase && in_box &&
                         (col == {1'b0, cursor_col}) &&
                         (row == {4'b0, cursor_row});
    stage0.hsync       = hsync_in;
    stage0.vsync       = vsync_in;
    stage0.hblnk       = hblnk_in;
    stage0.vblnk       = vblnk_in;
    stage0.hcount      = hcount_in;
    stage0.vcount      = vcount_in;
    stage0.rgb         = rgb_in;
    stage0.fg          = fg_rgb;
    stage0.bg          = bg_rgb;
    stage0.transparent = transparent;
  end

  // Stage 1 registers the ROM request; the pixel context then rides a delay line
  // until the glyph row comes back.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      char_addr <= '0;
      char_line <= '0;
      for (int i = 0; i <= ROM_LAT; i++) pipe[i] <= '0;
    end else begin
      char_addr <= in_box ? cell_addr : '0;
      char_line <= in_box ? cell_line : '0;
      pipe[0]   <= stage0;
      for (int i = 1; i <= ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Frame counter on vsync rising edges; blink_phase flips every BLINK_FRAMES.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev  <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_in && !vsync_prev) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Pick the glyph bit (bit 7 is leftmost), apply the cursor and composite.
  always_comb begin
    last      = pipe[ROM_LAT];
    glyph_bit = char_pixel[3'd7 - last.sub_x] ^ last.cursor_hit;
    rgb_next  = last.rgb;
    if (last.hblnk || last.vblnk || !last.in_box) begin
      rgb_next = last.rgb;
    end else if (glyph_bit) begin
      rgb_next = last.fg;
    end else begin
      rgb_next = last.transparent ? last.rgb : last.bg;
    end
  end

  // Output register: timing and the composited pixel leave together.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= last.hcount;
      vcount_out <= last.vcount;
      hsync_out  <= last.hsync;
      vsync_out  <= last.vsync;
      hblnk_out  <= last.hblnk;
      vblnk_out  <= last.vblnk;
      rgb_out    <= rgb_next;
    end
  end

endmodule
